saumauping_rst_ctrl: RTL and testbench

Parametrised reset controller for the SoC top level. It replaces the fixed 3-stage reset sync-in with a sequencer that drives NUM_DOMAINS high-active synchronous reset lines (CPU, Wishbone fabric, SD controller, peripherals). Domains are released in index order, with per-domain ready handshakes and timeouts. Software can re-reset any subset of domains without disturbing the others.

---
 rtl/saumauping_rst_ctrl.sv | 160 ++++++++++++++++
 tb/tb_saumauping_rst_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saumauping_rst_ctrl.sv
// saumauping_rst_ctrl: SoC reset sequencer.
// The external reset is synchronised, then NUM_DOMAINS high-active reset lines
// are released one at a time in index order. Each release waits for the
// domain's ready (or a timeout), then a gap, before the next domain goes.
// Software can later re-reset any subset without touching the others.
//
// Handshake: rdy_i[k] is a plain level, looked at only while domain k is the
// one being waited on and its reset is already released. swrst_req_i and
// swrst_mask_i are level-sampled on every clk edge and only act in DONE with
// a non-zero mask; at any other time they are ignored.
module saumauping_rst_ctrl #(
   parameter int SYNCIN      = 3,
   parameter int NUM_DOMAINS = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int STAGE_DELAY = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_DOMAINS-1:0] rdy_i,
   input  logic                   swrst_req_i,
   input  logic [NUM_DOMAINS-1:0] swrst_mask_i,
   output logic [NUM_DOMAINS-1:0] rst_o,
   output logic                   done_o,
   output logic                   busy_o,
   output logic [NUM_DOMAINS-1:0] timeout_o,
   output logic [1:0]             cause_o,
   output logic [1:0]             dbg_state_o
);

   localparam int MAX_HS  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
   localparam int MAX_CNT = (MAX_HS > TIMEOUT) ? MAX_HS : TIMEOUT;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam int KW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STAGE_LAST = CW'((STAGE_DELAY > 0) ? STAGE_DELAY - 1 : 0);
   localparam logic [CW-1:0] TO_LAST    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_HOLD, S_WAIT, S_GAP, S_DONE} state_t;

   logic [SYNCIN-1:0]      sync_q;
   logic                   r_sync;
   state_t                 state;
   logic [NUM_DOMAINS-1:0] sel;
   logic [KW-1:0]          k;
   logic [CW-1:0]          cnt;
   logic [KW-1:0]          first_k;
   logic [KW-1:0]          next_k;
   logic                   has_next;
   logic                   rdy_k;
   logic                   to_hit;

   assign r_sync      = sync_q[0];
   assign dbg_state_o = state;

   // Sync-in shift register: preset by rst_n, drains zeros towards bit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {1'b0, sync_q[SYNCIN-1:1]};
   end

   // Lowest selected domain: the first one a sequence releases.
   always_comb begin
      first_k = '0;
      for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
         if (sel[i]) first_k = KW'(i);
      end
   end

   // Lowest selected domain above the current one; unselected ones are skipped.
   always_comb begin
      next_k   = '0;
      has_next = 1'b0;
      for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
         if (sel[i] && (i > int'(k))) begin
            next_k   = KW'(i);
            has_next = 1'b1;
         end
      end
   end

   // Ready of the awaited domain; a flagged timeout acts as ready on the next edge.
   always_comb begin
      rdy_k  = (rdy_i[k] & ~rst_o[k]) | timeout_o[k];
      to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
   end

   // Sequencer: hold, then release domains in order with handshake, gap, timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HOLD;
         sel       <= '1;
         k         <= '0;
         cnt       <= '0;
         rst_o     <= '1;
         done_o    <= 1'b0;
         busy_o    <= 1'b1;
         timeout_o <= '0;
         cause_o   <= 2'b01;
      end else begin
         case (state)
            S_HOLD: begin
               if (r_sync) begin
                  cnt <= '0;
               end else if (cnt == HOLD_LAST) begin
                  rst_o[first_k] <= 1'b0;
                  k              <= first_k;
                  cnt            <= '0;
                  state          <= S_WAIT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_WAIT: begin
               if (rdy_k) begin
                  cnt <= '0;
                  if (!has_next) begin
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                     state  <= S_DONE;
                  end else if (STAGE_DELAY == 0) begin
                     rst_o[next_k] <= 1'b0;
                     k             <= next_k;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
                  if (to_hit) timeout_o[k] <= 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == STAGE_LAST) begin
                  rst_o[next_k] <= 1'b0;
                  k             <= next_k;
                  cnt           <= '0;
                  state         <= S_WAIT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (swrst_req_i && (swrst_mask_i != '0)) begin
                  rst_o     <= rst_o | swrst_mask_i;
                  sel       <= swrst_mask_i;
                  timeout_o <= timeout_o & ~swrst_mask_i;
                  cause_o   <= 2'b10;
                  done_o    <= 1'b0;
                  busy_o    <= 1'b1;
                  cnt       <= '0;
                  state     <= S_HOLD;
               end
            end
            default: state <= S_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_saumauping_rst_ctrl.sv
// tb_saumauping_rst_ctrl: directed tables, hand sequences and a random
// timeline model for the reset sequencer (defaults plus a TIMEOUT = 0 copy).
module tb_saumauping_rst_ctrl;

   localparam int N      = 4;
   localparam int SYNCIN = 3;
   localparam int HOLD   = 8;
   localparam int GAP    = 4;
   localparam int TO     = 64;
   localparam int N_RAND = 12;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   logic          rst_n, rst_z_n;
   logic [N-1:0]  rdy, mask, rst, tout;
   logic          req, done, busy;
   logic [1:0]    cause, dstate;
   logic [N-1:0]  rdy_z, mask_z, rst_z, tout_z;
   logic          req_z, done_z, busy_z;
   logic [1:0]    cause_z, dstate_z;

   saumauping_rst_ctrl dut (
      .clk(clk), .rst_n(rst_n), .rdy_i(rdy), .swrst_req_i(req), .swrst_mask_i(mask),
      .rst_o(rst), .done_o(done), .busy_o(busy), .timeout_o(tout), .cause_o(cause),
      .dbg_state_o(dstate)
   );

   saumauping_rst_ctrl #(.TIMEOUT(0)) dut_z (
      .clk(clk), .rst_n(rst_z_n), .rdy_i(rdy_z), .swrst_req_i(req_z), .swrst_mask_i(mask_z),
      .rst_o(rst_z), .done_o(done_z), .busy_o(busy_z), .timeout_o(tout_z), .cause_o(cause_z),
      .dbg_state_o(dstate_z)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   int rel    = 0;
   int relz   = 0;
   int rid    = 0;
   logic [N-1:0] m_rst = '1;
   logic [N-1:0] m_to  = '0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (edge %0d): got %h expected %h", name, ecnt, act, exp);
      end
   endtask

   typedef struct {
      int           edge_n;
      logic [N-1:0] exp_rst;
      logic         exp_done;
      logic         exp_busy;
      logic [N-1:0] exp_to;
      logic [1:0]   exp_cause;
      logic [N-1:0] nxt_rdy;
      logic         nxt_req;
      logic [N-1:0] nxt_mask;
   } vec_t;

   vec_t tab_po[$];
   vec_t tab_to[$];

   function automatic vec_t mk(input int e, input logic [N-1:0] r, input logic dn,
                               input logic bz, input logic [N-1:0] t, input logic [1:0] c,
                               input logic [N-1:0] nr, input logic nq, input logic [N-1:0] nm);
      vec_t v;
      v.edge_n = e;   v.exp_rst = r;  v.exp_done = dn; v.exp_busy = bz;
      v.exp_to = t;   v.exp_cause = c; v.nxt_rdy = nr; v.nxt_req = nq; v.nxt_mask = nm;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic to_edge(input int e);
      while (ecnt < e) @(negedge clk);
   endtask

   // Assert rst_n away from clk edges, check async reset values, release at a negedge.
   task automatic power_on(input logic [N-1:0] r0, input logic q0, input logic [N-1:0] m0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst",   16'(rst),   16'(4'hF));
      chk("async_done",  16'(done),  16'(1'b0));
      chk("async_busy",  16'(busy),  16'(1'b1));
      chk("async_to",    16'(tout),  16'(4'h0));
      chk("async_cause", 16'(cause), 16'(2'b01));
      rdy = r0; req = q0; mask = m0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rel   = ecnt;
   endtask

   task automatic apply_rec(input string nm, input vec_t v);
      to_edge(rel + v.edge_n);
      chk($sformatf("%s_rst@%0d",   nm, v.edge_n), 16'(rst),   16'(v.exp_rst));
      chk($sformatf("%s_done@%0d",  nm, v.edge_n), 16'(done),  16'(v.exp_done));
      chk($sformatf("%s_busy@%0d",  nm, v.edge_n), 16'(busy),  16'(v.exp_busy));
      chk($sformatf("%s_to@%0d",    nm, v.edge_n), 16'(tout),  16'(v.exp_to));
      chk($sformatf("%s_cause@%0d", nm, v.edge_n), 16'(cause), 16'(v.exp_cause));
      rdy = v.nxt_rdy; req = v.nxt_req; mask = v.nxt_mask;
   endtask

   // Random scenario: event times come from the release/ready/timeout rules,
   // then the expected output vector of every edge is queued and compared.
   task automatic run_scenario(input bit sw);
      logic [N-1:0]  sel, base_rst, base_to, flag, er, et;
      logic [1:0]    cz;
      logic [11:0]   exp_q[$];
      logic [11:0]   e_v;
      int            d[N];
      int            t_rel[N];
      int            t_flag[N];
      int            t, s, hs, done_e, last_exit;
      rid++;
      if (sw) begin
         sel      = N'($urandom_range(1, (1 << N) - 1));
         base_rst = m_rst | sel;
         base_to  = m_to & ~sel;
         cz       = 2'b10;
         req      = 1'b1;
         mask     = sel;
         hs       = ecnt + 1;
         s        = hs;
      end else begin
         sel      = '1;
         base_rst = '1;
         base_to  = '0;
         cz       = 2'b01;
         power_on(N'($urandom), 1'($urandom_range(0, 1)), N'($urandom));
         hs       = rel + SYNCIN;
         s        = rel;
      end
      t = hs + HOLD;
      last_exit = hs;
      flag = '0;
      for (int kk = 0; kk < N; kk++) begin
         d[kk] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO + 1, TO + 20))
                                             : int'($urandom_range(1, 50));
         t_rel[kk]  = 0;
         t_flag[kk] = 0;
         if (sel[kk]) begin
            t_rel[kk] = t;
            if (d[kk] <= TO) begin
               last_exit = t + d[kk];
            end else begin
               flag[kk]    = 1'b1;
               t_flag[kk]  = t + TO;
               last_exit   = t + TO + 1;
            end
            t = last_exit + GAP;
         end
      end
      done_e = last_exit;
      for (int n = s; n <= done_e + 3; n++) begin
         for (int kk = 0; kk < N; kk++) begin
            er[kk] = sel[kk] ? (n < t_rel[kk]) : base_rst[kk];
            et[kk] = sel[kk] ? (flag[kk] && (n >= t_flag[kk])) : base_to[kk];
         end
         exp_q.push_back({er, (n >= done_e), (n < done_e), et, cz});
      end
      e_v = '0;
      for (int n = s; n <= done_e + 3; n++) begin
         to_edge(n);
         e_v = exp_q.pop_front();
         chk($sformatf("rand%0d_vec@%0d", rid, n - s),
             16'({rst, done, busy, tout, cause}), 16'(e_v));
         for (int kk = 0; kk < N; kk++) begin
            if (sel[kk] && (n + 1 >= t_rel[kk])) rdy[kk] = (n + 1 >= t_rel[kk] + d[kk]);
            else                                  rdy[kk] = 1'($urandom_range(0, 1));
         end
         req  = 1'($urandom_range(0, 1));
         mask = (n + 1 <= done_e) ? N'($urandom) : '0;
      end
      req   = 1'b0;
      mask  = '0;
      m_rst = e_v[11:8];
      m_to  = e_v[5:2];
   endtask

   // ---------------- test ----------------
   initial begin
      int e0;
      rst_n = 1'b0; rdy = '0; req = 1'b0; mask = '0;
      rst_z_n = 1'b0; rdy_z = '0; req_z = 1'b0; mask_z = '0;

      // Power-on, all ready; requests held high while busy, then mask 0 in DONE.
      tab_po.push_back(mk( 2, 4'hF, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk( 3, 4'hF, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(10, 4'hF, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(11, 4'hE, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(15, 4'hE, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(16, 4'hC, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(20, 4'hC, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(21, 4'h8, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(25, 4'h8, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(26, 4'h0, 0, 1, 4'h0, 2'b01, 4'hF, 1, 4'hF));
      tab_po.push_back(mk(27, 4'h0, 1, 0, 4'h0, 2'b01, 4'hF, 1, 4'h0));
      tab_po.push_back(mk(29, 4'h0, 1, 0, 4'h0, 2'b01, 4'hF, 0, 4'h0));
      // Domain 1 never ready: timeout after 64 edges, sequence carries on.
      tab_to.push_back(mk(16, 4'hC, 0, 1, 4'h0, 2'b01, 4'hD, 0, 4'h0));
      tab_to.push_back(mk(79, 4'hC, 0, 1, 4'h0, 2'b01, 4'hD, 0, 4'h0));
      tab_to.push_back(mk(80, 4'hC, 0, 1, 4'h2, 2'b01, 4'hD, 0, 4'h0));
      tab_to.push_back(mk(84, 4'hC, 0, 1, 4'h2, 2'b01, 4'hD, 0, 4'h0));
      tab_to.push_back(mk(85, 4'h8, 0, 1, 4'h2, 2'b01, 4'hD, 0, 4'h0));
      tab_to.push_back(mk(89, 4'h8, 0, 1, 4'h2, 2'b01, 4'hD, 0, 4'h0));
      tab_to.push_back(mk(90, 4'h0, 0, 1, 4'h2, 2'b01, 4'hD, 0, 4'h0));
      tab_to.push_back(mk(91, 4'h0, 1, 0, 4'h2, 2'b01, 4'hD, 0, 4'h0));

      power_on(4'hF, 1'b1, 4'hF);
      foreach (tab_po[i]) apply_rec("po", tab_po[i]);

      // Software re-reset of domains 1 and 3.
      req = 1'b1; mask = 4'b1010;
      e0 = ecnt + 1;
      to_edge(e0);
      req = 1'b0; mask = '0;
      chk("sw_rst@0",   16'(rst),   16'(4'hA));
      chk("sw_cause@0", 16'(cause), 16'(2'b10));
      chk("sw_done@0",  16'(done),  16'(1'b0));
      chk("sw_busy@0",  16'(busy),  16'(1'b1));
      to_edge(e0 + 7);  chk("sw_rst@7",  16'(rst), 16'(4'hA));
      to_edge(e0 + 8);  chk("sw_rst@8",  16'(rst), 16'(4'h8));
      to_edge(e0 + 12); chk("sw_rst@12", 16'(rst), 16'(4'h8));
      to_edge(e0 + 13); chk("sw_rst@13", 16'(rst), 16'(4'h0));
      chk("sw_done@13", 16'(done), 16'(1'b0));
      to_edge(e0 + 14);
      chk("sw_done@14",  16'(done),   16'(1'b1));
      chk("sw_busy@14",  16'(busy),   16'(1'b0));
      chk("sw_cause@14", 16'(cause),  16'(2'b10));
      chk("sw_state@14", 16'(dstate), 16'(2'd3));

      power_on(4'hD, 1'b0, 4'h0);
      foreach (tab_to[i]) apply_rec("to", tab_to[i]);

      // Reset from DONE with a sticky timeout, then a pulse mid-sequence.
      power_on(4'hF, 1'b1, 4'hF);
      to_edge(rel + 17);
      chk("pre_pulse_rst", 16'(rst), 16'(4'hC));
      power_on(4'hF, 1'b1, 4'hF);
      foreach (tab_po[i]) apply_rec("po2", tab_po[i]);

      // TIMEOUT = 0: waits on domain 2 indefinitely.
      rdy_z = 4'b1011;
      @(negedge clk);
      rst_z_n = 1'b1;
      relz    = ecnt;
      to_edge(relz + 21);  chk("tz_rst@21",  16'(rst_z), 16'(4'h8));
      to_edge(relz + 221);
      chk("tz_rst@221",  16'(rst_z),  16'(4'h8));
      chk("tz_to@221",   16'(tout_z), 16'(4'h0));
      chk("tz_busy@221", 16'(busy_z), 16'(1'b1));
      rdy_z = 4'hF;
      to_edge(relz + 225); chk("tz_rst@225",  16'(rst_z),  16'(4'h8));
      to_edge(relz + 226); chk("tz_rst@226",  16'(rst_z),  16'(4'h0));
      to_edge(relz + 227); chk("tz_done@227", 16'(done_z), 16'(1'b1));

      // Random scenarios against the timeline model.
      run_scenario(1'b0);
      for (int i = 1; i < N_RAND; i++) run_scenario($urandom_range(0, 3) != 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached at edge %0d", ecnt);
      $fatal(1, "watchdog");
   end

endmodule
